// File: rtl/ip_codma_task_sched_pkg.sv
// Shared types for the CoDMA task scheduler: FSM state encoding and the
// queued descriptor layout.
package ip_codma_task_sched_pkg;

  // Wide enough for the largest supported requester count (8).
  localparam int SCHED_ID_W = 3;
  localparam int SCHED_PTR_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    RUN,
    DONE,
    ABORT
  } sched_state_t;

  typedef struct packed {
    logic [SCHED_ID_W-1:0]  id;
    logic [SCHED_PTR_W-1:0] task_ptr;
    logic [SCHED_PTR_W-1:0] status_ptr;
  } sched_entry_t;

endpackage

// File: rtl/ip_codma_task_sched_fifo.sv
// Small synchronous descriptor FIFO with flush. Storage is not reset; only
// the pointers and the occupancy count are.
module ip_codma_task_fifo
  import ip_codma_task_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        push_i,
  input  sched_entry_t                push_data_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  output sched_entry_t                pop_data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  sched_entry_t  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full_o     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign empty_o    = (r_count == '0);
  assign count_o    = r_count;
  assign pop_data_o = r_mem[r_rd_ptr];
  assign w_push     = push_i && !full_o && !flush_i;
  assign w_pop      = pop_i && !empty_o && !flush_i;

  // Pointer and occupancy bookkeeping; flush discards everything queued.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Descriptor storage write port.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/ip_codma_task_sched.sv
// Shares one CoDMA engine between NUM_REQ requesters: round-robin intake
// into a descriptor FIFO, then one task at a time through start/busy/irq,
// with a completion pulse tagged by requester.
module ip_codma_task_sched
  import ip_codma_task_sched_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int START_HOLD   = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*32-1:0]       req_task_ptr_i,
  input  logic [NUM_REQ*32-1:0]       req_status_ptr_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic                        abort_i,
  output logic                        start_o,
  output logic                        stop_o,
  output logic [31:0]                 task_pointer_o,
  output logic [31:0]                 status_pointer_o,
  input  logic                        busy_i,
  input  logic                        irq_i,
  output logic                        done_o,
  output logic [$clog2(NUM_REQ)-1:0]  done_id_o,
  output logic                        done_err_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic                        sched_busy_o
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(START_HOLD + 1);
  localparam int TO_W   = $clog2(BUSY_TIMEOUT + 1);

  sched_state_t      r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_cur_id;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_busy_seen;
  logic              r_err;
  logic              r_start;
  logic              r_stop;
  logic              r_done;
  logic [ID_W-1:0]   r_done_id;
  logic              r_done_err;
  logic [31:0]       r_task_ptr;
  logic [31:0]       r_status_ptr;

  logic              w_any_valid;
  logic [ID_W-1:0]   w_grant_idx;
  logic [ID_W-1:0]   w_cand;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  sched_entry_t      w_push_entry;
  sched_entry_t      w_fifo_rd;
  logic              w_unused_id;

  // Round-robin search starting at r_rr_ptr; first valid requester wins.
  always_comb begin
    w_any_valid = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_any_valid && req_valid_i[w_cand]) begin
        w_any_valid = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  assign req_ready_o = (w_any_valid && !w_fifo_full && !abort_i)
                       ? (NUM_REQ'(1) << w_grant_idx) : '0;
  assign w_push      = |(req_valid_i & req_ready_o);
  // A pop only ever happens on the IDLE -> LAUNCH step.
  assign w_pop       = (r_state == IDLE) && !w_fifo_empty && !abort_i;

  assign w_push_entry.id         = SCHED_ID_W'(w_grant_idx);
  assign w_push_entry.task_ptr   = req_task_ptr_i[32*int'(w_grant_idx) +: 32];
  assign w_push_entry.status_ptr = req_status_ptr_i[32*int'(w_grant_idx) +: 32];
  assign w_unused_id             = ^w_fifo_rd.id;

  ip_codma_task_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (w_push),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .flush_i     (abort_i),
    .pop_data_o  (w_fifo_rd),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty),
    .count_o     (fifo_count_o)
  );

  // Advance the round-robin pointer past the requester just accepted.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_rr_ptr <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
    end
  end

  // Task sequencing FSM with registered CoDMA control and completion outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_cur_id     <= '0;
      r_hold_cnt   <= '0;
      r_to_cnt     <= '0;
      r_busy_seen  <= 1'b0;
      r_err        <= 1'b0;
      r_start      <= 1'b0;
      r_stop       <= 1'b0;
      r_done       <= 1'b0;
      r_done_id    <= '0;
      r_done_err   <= 1'b0;
      r_task_ptr   <= '0;
      r_status_ptr <= '0;
    end else begin
      r_done <= 1'b0;
      r_stop <= 1'b0;
      // The busy timeout counts from LAUNCH entry and saturates.
      if ((r_state == LAUNCH || r_state == WAIT_BUSY) && r_to_cnt != TO_W'(BUSY_TIMEOUT))
        r_to_cnt <= r_to_cnt + 1'b1;
      if ((r_state == LAUNCH || r_state == WAIT_BUSY || r_state == RUN) && irq_i)
        r_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_task_ptr   <= w_fifo_rd.task_ptr;
            r_status_ptr <= w_fifo_rd.status_ptr;
            r_cur_id     <= w_fifo_rd.id[ID_W-1:0];
            r_err        <= 1'b0;
            r_busy_seen  <= 1'b0;
            r_hold_cnt   <= '0;
            r_to_cnt     <= '0;
            r_start      <= 1'b1;
            r_state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (busy_i) r_busy_seen <= 1'b1;
          if (r_hold_cnt == HOLD_W'(START_HOLD - 1)) begin
            r_start <= 1'b0;
            r_state <= (r_busy_seen || busy_i) ? RUN : WAIT_BUSY;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        WAIT_BUSY: begin
          if (busy_i) begin
            r_state <= RUN;
          end else if (r_to_cnt >= TO_W'(BUSY_TIMEOUT - 1)) begin
            r_done     <= 1'b1;
            r_done_id  <= r_cur_id;
            r_done_err <= 1'b1;
            r_state    <= DONE;
          end
        end
        RUN: begin
          if (!busy_i) begin
            r_done     <= 1'b1;
            r_done_id  <= r_cur_id;
            r_done_err <= r_err || irq_i;
            r_state    <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        ABORT: begin
          if (!r_stop && !busy_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // Abort pre-empts an active task; IDLE, DONE and ABORT ignore it.
      if (abort_i && (r_state == LAUNCH || r_state == WAIT_BUSY || r_state == RUN)) begin
        r_state <= ABORT;
        r_stop  <= 1'b1;
        r_start <= 1'b0;
        r_done  <= 1'b0;
      end
    end
  end

  assign start_o          = r_start;
  assign stop_o           = r_stop;
  assign done_o           = r_done;
  assign done_id_o        = r_done_id;
  assign done_err_o       = r_done_err;
  assign task_pointer_o   = r_task_ptr;
  assign status_pointer_o = r_status_ptr;
  assign sched_busy_o     = (r_state != IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_ip_codma_task_sched.sv
// Bench for ip_codma_task_sched: requester queues feed the DUT, accepted
// descriptors go to a scoreboard, and a behavioural CoDMA answers each launch
// using the timing stored with the descriptor at the scoreboard head.
module tb_ip_codma_task_sched;

  localparam int NUM_REQ      = 2;
  localparam int FIFO_DEPTH   = 4;
  localparam int START_HOLD   = 4;
  localparam int BUSY_TIMEOUT = 16;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [1:0]  req_valid_i;
  logic [63:0] req_task_ptr_i;
  logic [63:0] req_status_ptr_i;
  logic [1:0]  req_ready_o;
  logic        abort_i;
  logic        start_o;
  logic        stop_o;
  logic [31:0] task_pointer_o;
  logic [31:0] status_pointer_o;
  logic        busy_i;
  logic        irq_i;
  logic        done_o;
  logic [0:0]  done_id_o;
  logic        done_err_o;
  logic [2:0]  fifo_count_o;
  logic        sched_busy_o;

  ip_codma_task_sched #(
    .NUM_REQ      (NUM_REQ),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .START_HOLD   (START_HOLD),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .req_valid_i      (req_valid_i),
    .req_task_ptr_i   (req_task_ptr_i),
    .req_status_ptr_i (req_status_ptr_i),
    .req_ready_o      (req_ready_o),
    .abort_i          (abort_i),
    .start_o          (start_o),
    .stop_o           (stop_o),
    .task_pointer_o   (task_pointer_o),
    .status_pointer_o (status_pointer_o),
    .busy_i           (busy_i),
    .irq_i            (irq_i),
    .done_o           (done_o),
    .done_id_o        (done_id_o),
    .done_err_o       (done_err_o),
    .fifo_count_o     (fifo_count_o),
    .sched_busy_o     (sched_busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] tp;
    logic [31:0] sp;
    int          id;
    int          delay;
    int          len;
    int          irq_at;
    bit          never;
    bit          err;
  } desc_t;

  desc_t rq0[$];
  desc_t rq1[$];
  desc_t sb[$];
  int    acc_log[$];
  bit    acc0, acc1;
  int    cyc, start_cyc, start_cnt, stop_cnt, stop_pulses;
  logic  start_q, stop_q, mstart_q;
  desc_t mon_d;
  desc_t mdl_d;
  int    n_checks, n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic desc_t mk(input int id, input logic [31:0] tp, input logic [31:0] sp,
                               input int delay, input int len, input int irq_at, input bit never);
    desc_t d;
    d.tp     = tp;
    d.sp     = sp;
    d.id     = id;
    d.delay  = delay;
    d.len    = len;
    d.irq_at = irq_at;
    d.never  = never;
    d.err    = never || (irq_at >= 0 && irq_at < len);
    return d;
  endfunction

  // Requester drivers: present the head of each queue, retire it after acceptance.
  always @(posedge clk_i) begin
    #1;
    if (acc0) begin if (rq0.size() > 0) rq0.delete(0); acc0 = 1'b0; end
    if (acc1) begin if (rq1.size() > 0) rq1.delete(0); acc1 = 1'b0; end
    req_valid_i[0]          = (rq0.size() > 0);
    req_task_ptr_i[31:0]    = (rq0.size() > 0) ? rq0[0].tp : 32'h0;
    req_status_ptr_i[31:0]  = (rq0.size() > 0) ? rq0[0].sp : 32'h0;
    req_valid_i[1]          = (rq1.size() > 0);
    req_task_ptr_i[63:32]   = (rq1.size() > 0) ? rq1[0].tp : 32'h0;
    req_status_ptr_i[63:32] = (rq1.size() > 0) ? rq1[0].sp : 32'h0;
  end

  // Monitor: acceptance into the scoreboard, start/stop pulse widths, completions.
  always @(negedge clk_i) begin
    cyc++;
    if (reset_i) begin
      start_cnt = 0;
      stop_cnt  = 0;
      start_q   = 1'b0;
      stop_q    = 1'b0;
    end else begin
      if (req_valid_i[0] && req_ready_o[0] && rq0.size() > 0) begin
        sb.push_back(rq0[0]); acc0 = 1'b1; acc_log.push_back(0);
      end
      if (req_valid_i[1] && req_ready_o[1] && rq1.size() > 0) begin
        sb.push_back(rq1[0]); acc1 = 1'b1; acc_log.push_back(1);
      end
      if (fifo_count_o == 3'(FIFO_DEPTH)) check("ready_while_full", 32'(req_ready_o), 32'h0);
      if (start_o) begin
        if (!start_q) start_cyc = cyc;
        start_cnt++;
      end else if (start_q) begin
        check("start_len", 32'(start_cnt), 32'(START_HOLD));
        start_cnt = 0;
      end
      if (stop_o) begin
        if (!stop_q) stop_pulses++;
        stop_cnt++;
      end else if (stop_q) begin
        check("stop_len", 32'(stop_cnt), 32'd1);
        stop_cnt = 0;
      end
      if (done_o) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          mon_d = sb.pop_front();
          check("done_id", 32'(done_id_o), 32'(mon_d.id));
          check("done_err", 32'(done_err_o), 32'(mon_d.err));
          check("task_ptr", task_pointer_o, mon_d.tp);
          check("status_ptr", status_pointer_o, mon_d.sp);
          check("done_latency", 32'(cyc - start_cyc),
                mon_d.never ? 32'(BUSY_TIMEOUT) : 32'(mon_d.delay + mon_d.len + 1));
        end
      end
      start_q = start_o;
      stop_q  = stop_o;
    end
  end

  // Behavioural CoDMA: busy after `delay` cycles for `len` cycles, optional irq,
  // busy dropped two cycles after a stop request.
  task automatic codma_run(input desc_t d);
    if (d.never) return;
    for (int i = 0; i < d.delay; i++) begin
      @(posedge clk_i); #1;
      if (reset_i) return;
    end
    busy_i = 1'b1;
    for (int c = 0; c < d.len; c++) begin
      irq_i = (c == d.irq_at);
      @(posedge clk_i); #1;
      if (reset_i) begin busy_i = 1'b0; irq_i = 1'b0; return; end
      if (stop_o) begin
        irq_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        busy_i = 1'b0;
        return;
      end
    end
    irq_i  = 1'b0;
    busy_i = 1'b0;
  endtask

  initial begin
    busy_i   = 1'b0;
    irq_i    = 1'b0;
    mstart_q = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!reset_i && start_o && !mstart_q && sb.size() > 0) begin
        mdl_d = sb[0];
        codma_run(mdl_d);
      end
      mstart_q = start_o;
    end
  end

  task automatic wait_drain(input int budget, input string tag);
    for (int i = 0; i < budget && (sb.size() != 0 || rq0.size() != 0 ||
                                   rq1.size() != 0 || sched_busy_o); i++)
      @(negedge clk_i);
    check(tag, 32'(sb.size() + rq0.size() + rq1.size()) | 32'(sched_busy_o), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; start_cyc = 0; stop_pulses = 0;
    acc0 = 1'b0; acc1 = 1'b0;
    reset_i = 1'b1; abort_i = 1'b0;
    req_valid_i = '0; req_task_ptr_i = '0; req_status_ptr_i = '0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_start", 32'(start_o), 32'h0);
    check("rst_stop", 32'(stop_o), 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_done_id", 32'(done_id_o), 32'h0);
    check("rst_done_err", 32'(done_err_o), 32'h0);
    check("rst_task_ptr", task_pointer_o, 32'h0);
    check("rst_status_ptr", status_pointer_o, 32'h0);
    check("rst_fifo_count", 32'(fifo_count_o), 32'h0);
    check("rst_sched_busy", 32'(sched_busy_o), 32'h0);
    check("rst_ready", 32'(req_ready_o), 32'h0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;

    // Fairness: both requesters hold valid for three descriptors each
    acc_log.delete();
    for (int i = 0; i < 3; i++) begin
      rq0.push_back(mk(0, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16), 2, 12, -1, 1'b0));
      rq1.push_back(mk(1, 32'h3000 + 32'(i * 16), 32'h3800 + 32'(i * 16), 2, 12, -1, 1'b0));
    end
    for (int i = 0; i < 100 && fifo_count_o != 3'(FIFO_DEPTH); i++) @(negedge clk_i);
    check("fifo_full", 32'(fifo_count_o), 32'(FIFO_DEPTH));
    check("ready_full", 32'(req_ready_o), 32'h0);
    wait_drain(600, "drain_fair");
    check("acc_count", 32'(acc_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < acc_log.size(); i++)
      check("acc_order", 32'(acc_log[i]), 32'(i % 2));

    // Single task: busy 3 cycles after start, 20 cycles long
    rq0.push_back(mk(0, 32'h80, 32'h0, 3, 20, -1, 1'b0));
    wait_drain(200, "drain_single");

    // Busy timeout, then the next queued task runs normally
    rq1.push_back(mk(1, 32'h4000, 32'h4100, 0, 0, -1, 1'b1));
    rq1.push_back(mk(1, 32'h4200, 32'h4300, 2, 6, -1, 1'b0));
    wait_drain(200, "drain_timeout");

    // irq during RUN flags only that task
    rq0.push_back(mk(0, 32'h5000, 32'h5100, 2, 12, 5, 1'b0));
    rq0.push_back(mk(0, 32'h5200, 32'h5300, 2, 12, -1, 1'b0));
    wait_drain(200, "drain_irq");

    // Abort during RUN with two descriptors still queued
    stop_pulses = 0;
    for (int i = 0; i < 3; i++)
      rq0.push_back(mk(0, 32'h6000 + 32'(i * 16), 32'h6800 + 32'(i * 16), 2, 60, -1, 1'b0));
    for (int i = 0; i < 100 && !(rq0.size() == 0 && busy_i); i++) @(negedge clk_i);
    repeat (4) @(negedge clk_i);
    check("abort_pre_count", 32'(fifo_count_o), 32'd2);
    @(posedge clk_i); #1;
    abort_i = 1'b1;
    sb.delete();
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    @(negedge clk_i);
    check("abort_flush", 32'(fifo_count_o), 32'h0);
    check("abort_stop", 32'(stop_o), 32'h1);
    for (int i = 0; i < 30 && sched_busy_o; i++) @(negedge clk_i);
    check("abort_idle", 32'(sched_busy_o), 32'h0);
    repeat (5) @(negedge clk_i);
    check("abort_stop_pulses", 32'(stop_pulses), 32'd1);
    check("abort_no_pending", 32'(sb.size()), 32'h0);

    // Reset asserted mid-LAUNCH clears outputs immediately
    rq1.push_back(mk(1, 32'h7000, 32'h7100, 3, 10, -1, 1'b0));
    for (int i = 0; i < 50 && !start_o; i++) @(negedge clk_i);
    check("launch_seen", 32'(start_o), 32'h1);
    @(posedge clk_i); #2;
    reset_i = 1'b1;
    #1;
    sb.delete();
    check("mid_rst_start", 32'(start_o), 32'h0);
    check("mid_rst_stop", 32'(stop_o), 32'h0);
    check("mid_rst_done", 32'(done_o), 32'h0);
    check("mid_rst_task_ptr", task_pointer_o, 32'h0);
    check("mid_rst_status_ptr", status_pointer_o, 32'h0);
    check("mid_rst_fifo_count", 32'(fifo_count_o), 32'h0);
    check("mid_rst_sched_busy", 32'(sched_busy_o), 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // Recovery after reset
    rq0.push_back(mk(0, 32'h8000, 32'h8100, 1, 5, -1, 1'b0));
    wait_drain(100, "drain_recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
